// File: rtl/elastic_pipeline.sv
// elastic_pipeline: DEPTH-stage valid/ready pipeline with bubble collapse and
// one input skid register, giving a total capacity of DEPTH+1 words.
// ready_out is registered, so there is no combinational path from ready_in.
// Optional feature: define ELASTIC_PIPE_COUNT_EN to add the registered
// occupancy output count_out.
module elastic_pipeline #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [WIDTH-1:0] val_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] val_out,
   output logic             valid_out,
   input  logic             ready_in
`ifdef ELASTIC_PIPE_COUNT_EN
   ,
   output logic [$clog2(DEPTH+2)-1:0] count_out
`endif
);

   localparam int CW = $clog2(DEPTH+2);

   logic [WIDTH-1:0] data_reg  [DEPTH];
   logic [WIDTH-1:0] data_next [DEPTH];
   logic [DEPTH-1:0] valid_reg;
   logic [DEPTH-1:0] valid_next;
   logic [WIDTH-1:0] skid_data_reg;
   logic [WIDTH-1:0] skid_data_next;
   logic             skid_valid_reg;
   logic             skid_valid_next;
   logic             ready_reg;
   logic [DEPTH-1:0] load;
   logic             in_fire;

   assign in_fire = valid_in && ready_reg;

   // Stage i loads when it, or any stage downstream of it, has a hole, or the
   // consumer is taking the last word (unrolled bubble-collapse chain).
   always_comb begin
      logic chain;
      load  = '0;
      chain = ready_in;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         chain   = chain || !valid_reg[i];
         load[i] = chain;
      end
   end

   // Next-state of the stage registers: stage 0 prefers the skid word so that
   // order is preserved; later stages take their predecessor.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_next[i] = valid_reg[i];
         data_next[i]  = data_reg[i];
      end
      if (load[0]) begin
         valid_next[0] = skid_valid_reg || in_fire;
         data_next[0]  = skid_valid_reg ? skid_data_reg : val_in;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (load[i]) begin
            valid_next[i] = valid_reg[i-1];
            data_next[i]  = data_reg[i-1];
         end
      end
   end

   // Skid register: drains into stage 0 when it can, captures an accepted word
   // that stage 0 cannot take. While it is full ready_out is low, so a new
   // input can never arrive while it holds a word.
   always_comb begin
      skid_valid_next = skid_valid_reg;
      skid_data_next  = skid_data_reg;
      if (skid_valid_reg && load[0]) begin
         skid_valid_next = 1'b0;
      end else if (!skid_valid_reg && in_fire && !load[0]) begin
         skid_valid_next = 1'b1;
         skid_data_next  = val_in;
      end
   end

`ifdef ELASTIC_PIPE_COUNT_EN
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // Occupancy after the coming edge: valid stages plus the skid word.
   always_comb begin
      count_next = CW'(skid_valid_next);
      for (int i = 0; i < DEPTH; i++) begin
         count_next = count_next + CW'(valid_next[i]);
      end
   end

   assign count_out = count_reg;
`endif

   // State registers; reset empties the pipe and holds ready_out low until the
   // first edge after release.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= '0;
         end
         valid_reg      <= '0;
         skid_data_reg  <= '0;
         skid_valid_reg <= 1'b0;
         ready_reg      <= 1'b0;
`ifdef ELASTIC_PIPE_COUNT_EN
         count_reg      <= '0;
`endif
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= data_next[i];
         end
         valid_reg      <= valid_next;
         skid_data_reg  <= skid_data_next;
         skid_valid_reg <= skid_valid_next;
         ready_reg      <= !skid_valid_next;
`ifdef ELASTIC_PIPE_COUNT_EN
         count_reg      <= count_next;
`endif
      end
   end

   assign ready_out = ready_reg;
   assign val_out   = data_reg[DEPTH-1];
   assign valid_out = valid_reg[DEPTH-1];

endmodule
